mcpu_seq_alu: RTL
=================

Name: mcpu_seq_alu

Overview:
- Registered, handshaked successor to the MCPU combinational ALU.
- Generalised to WORD_SIZE bits and 8 opcodes. Legacy AND/OR/XOR/ADD encodings are kept; SUB, SHL, SHR and an iterative MUL are added.
- Produces a full status flag set.
- Sits between the MCPU decode stage (valid/ready producer) and writeback (valid/ready consumer). Single-issue: one operation is in flight at a time.

Parameters:
- WORD_SIZE, 8, operand/result width in bits; must be 2 or greater.
- CMD_SIZE, 3, opcode width; fixed at 3 (8 opcodes), other values unsupported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation this cycle.
- opcode  input  CMD_SIZE  0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SHL, 6 SHR, 7 MUL.
- r1  input  WORD_SIZE  operand A.
- r2  input  WORD_SIZE  operand B, or the shift amount.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WORD_SIZE  result.
- carry  output  1  carry/borrow flag.
- overflow  output  1  signed overflow (ADD/SUB) or product truncation (MUL).
- zero  output  1  out equals 0.
- negative  output  1  out[WORD_SIZE-1].
- busy  output  1  MUL iteration in progress (state EXEC).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0; out=0; carry=overflow=zero=negative=0; busy=0; in_ready=0 while rst_n is low.
  - Asserting reset mid-MUL aborts the operation; no result is produced.
- States: IDLE, EXEC, DONE.
- in_ready (combinational):
  - 1 in IDLE.
  - In DONE, equals out_ready.
  - 0 in EXEC.
- Accept: in_valid && in_ready on a rising edge latches opcode, r1 and r2.
- Single-cycle ops (0–6): result and flags are registered at the accept edge. Next state is DONE, so out_valid rises 1 cycle after accept.
- MUL (7):
  - Accept moves to EXEC and clears a WORD_SIZE-cycle counter and a 2*WORD_SIZE accumulator.
  - Each cycle adds the shifted multiplicand when the current multiplier bit is 1.
  - After WORD_SIZE EXEC cycles, moves to DONE. out_valid rises WORD_SIZE+1 cycles after accept.
- DONE:
  - out and flags are held stable while out_ready=0.
  - out_valid && out_ready with no new accept: go to IDLE, out_valid=0 next cycle.
  - out_valid && out_ready with a simultaneous accept: the new op is processed as if from IDLE, giving back-to-back throughput of 1 op/cycle for ops 0–6.
- Arithmetic (all results are modulo 2^WORD_SIZE):
  - AND/OR/XOR: bitwise; carry=0, overflow=0.
  - ADD: carry=bit WORD_SIZE of the (WORD_SIZE+1)-bit sum. overflow=1 when the operand signs match and the result sign differs.
  - SUB: out=r1-r2; carry=1 when r1<r2 unsigned (borrow). overflow=1 when the operand signs differ and the result sign differs from r1.
  - SHL/SHR: logical shift of r1 by unsigned r2. If r2>=WORD_SIZE, out=0. carry=last bit shifted out (0 when r2=0; 0 when r2>WORD_SIZE). overflow=0.
  - MUL: unsigned; out=low half of the product. overflow=1 when the high half is nonzero; carry=0.
  - zero and negative are always derived from the registered out.
- in_valid while in_ready=0 is ignored. The producer must hold its request until accepted.
- out_valid never deasserts without out_ready. out and flags never change while out_valid=1 && out_ready=0.

Test Plan:
- Reset/idle (WORD_SIZE=8):
  - Assert rst_n=0 mid-MUL (cycle 3 of EXEC) -> out_valid=0, out=0, all flags 0, busy=0 immediately.
  - After release, in_ready=1 and no stale result appears.
- Legacy ops:
  - AND r1=8'hF0, r2=8'h3C -> out=8'h30, 1 cycle later.
  - OR -> 8'hFC; XOR -> 8'hCC.
  - All with carry=0, overflow=0, negative=1 except AND (negative=0).
- ADD/SUB edges:
  - ADD 8'h7F+8'h01 -> 8'h80, overflow=1, carry=0, negative=1.
  - ADD 8'hFF+8'h01 -> 8'h00, carry=1, zero=1.
  - SUB 8'h00-8'h01 -> 8'hFF, carry=1.
  - SUB 8'h80-8'h01 -> 8'h7F, overflow=1.
- Shifts:
  - SHL 8'h81 by 1 -> 8'h02, carry=1.
  - SHR 8'h81 by 0 -> 8'h81, carry=0.
  - SHL by 8 -> 8'h00, carry=1.
  - SHR by 9 -> 8'h00, carry=0.
- MUL:
  - 8'h0F*8'h11 -> 8'hFF, overflow=0, out_valid exactly 9 cycles after accept, busy=1 for 8 cycles, in_ready=0 throughout.
  - 8'h10*8'h10 -> 8'h00, overflow=1, zero=1.
- Backpressure/back-to-back:
  - Hold out_ready=0 for 5 cycles -> out/flags constant, in_ready=0.
  - Then drive out_ready=1 with in_valid=1 every cycle for 4 ADDs -> one result per cycle, none dropped or duplicated.
  - Random ops vs reference model: zero mismatches over 10k ops.

Source files
------------

// File: rtl/mcpu_seq_alu_if.sv
// Handshake and data bundle between MCPU decode, the sequential ALU and writeback.
// The ALU takes the slave side; decode/writeback (or a testbench) takes the master side.
interface mcpu_seq_alu_if #(
  parameter int WORD_SIZE = 8,
  parameter int CMD_SIZE  = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CMD_SIZE-1:0]  opcode;
  logic [WORD_SIZE-1:0] r1;
  logic [WORD_SIZE-1:0] r2;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out;
  logic                 carry;
  logic                 overflow;
  logic                 zero;
  logic                 negative;
  logic                 busy;

  modport master (
    output in_valid, opcode, r1, r2, out_ready,
    input  in_ready, out_valid, out, carry, overflow, zero, negative, busy
  );

  modport slave (
    input  in_valid, opcode, r1, r2, out_ready,
    output in_ready, out_valid, out, carry, overflow, zero, negative, busy
  );
endinterface

// File: rtl/mcpu_seq_alu.sv
// Registered, valid/ready handshaked MCPU ALU: single-cycle logic/add/sub/shift ops
// and an iterative shift-add multiplier, one operation in flight at a time.
module mcpu_seq_alu #(
  parameter int WORD_SIZE = 8,
  parameter int CMD_SIZE  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  mcpu_seq_alu_if.slave bus
);
  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam logic [CMD_SIZE-1:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CMD_SIZE-1:0]    op_s;
  logic                   accept_s;
  logic                   last_s;
  logic [WORD_SIZE-1:0]   res_s;
  logic                   carry_s;
  logic                   ovf_s;
  logic [WORD_SIZE:0]     sum_s;
  logic [WORD_SIZE:0]     diff_s;
  logic [WORD_SIZE:0]     shl_s;
  logic [WORD_SIZE:0]     shr_s;

  logic [WORD_SIZE-1:0]   out_q;
  logic                   carry_q;
  logic                   ovf_q;
  logic                   zero_q;
  logic                   neg_q;
  logic [WORD_SIZE-1:0]   mplier_q;
  logic [2*WORD_SIZE-1:0] mcand_q;
  logic [2*WORD_SIZE-1:0] acc_q;
  logic [2*WORD_SIZE-1:0] acc_d;
  logic [CNT_W-1:0]       cnt_q;

  assign op_s     = bus.opcode;
  assign bus.in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept_s = bus.in_valid & bus.in_ready;
  assign last_s   = (state_q == EXEC) && (cnt_q == CNT_W'(WORD_SIZE - 1));
  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == EXEC);
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;

  // Single-cycle result and flags for opcodes 0-6.
  // Shifts go through a one-bit-wider word so the last bit shifted out lands in the spare bit.
  always_comb begin
    sum_s   = {1'b0, bus.r1} + {1'b0, bus.r2};
    diff_s  = {1'b0, bus.r1} - {1'b0, bus.r2};
    shl_s   = {1'b0, bus.r1} << bus.r2;
    shr_s   = {bus.r1, 1'b0} >> bus.r2;
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op_s)
      3'd0: res_s = bus.r1 & bus.r2;
      3'd1: res_s = bus.r1 | bus.r2;
      3'd2: res_s = bus.r1 ^ bus.r2;
      3'd3: begin
        res_s   = sum_s[WORD_SIZE-1:0];
        carry_s = sum_s[WORD_SIZE];
        ovf_s   = (bus.r1[WORD_SIZE-1] == bus.r2[WORD_SIZE-1]) &&
                  (sum_s[WORD_SIZE-1] != bus.r1[WORD_SIZE-1]);
      end
      3'd4: begin
        res_s   = diff_s[WORD_SIZE-1:0];
        carry_s = diff_s[WORD_SIZE];
        ovf_s   = (bus.r1[WORD_SIZE-1] != bus.r2[WORD_SIZE-1]) &&
                  (diff_s[WORD_SIZE-1] != bus.r1[WORD_SIZE-1]);
      end
      3'd5: begin
        res_s   = shl_s[WORD_SIZE-1:0];
        carry_s = shl_s[WORD_SIZE];
      end
      3'd6: begin
        res_s   = shr_s[WORD_SIZE:1];
        carry_s = shr_s[0];
      end
      default: res_s = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an accept in DONE restarts exactly as it would from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = (op_s == OP_MUL) ? EXEC : DONE;
        else          state_d = IDLE;
      end
      EXEC: begin
        if (last_s) state_d = DONE;
        else        state_d = EXEC;
      end
      DONE: begin
        if (accept_s)           state_d = (op_s == OP_MUL) ? EXEC : DONE;
        else if (bus.out_ready) state_d = IDLE;
        else                    state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result/flag registers and shift-add multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept_s) begin
      if (op_s == OP_MUL) begin
        acc_q    <= '0;
        cnt_q    <= '0;
        mcand_q  <= {{WORD_SIZE{1'b0}}, bus.r1};
        mplier_q <= bus.r2;
      end else begin
        out_q   <= res_s;
        carry_q <= carry_s;
        ovf_q   <= ovf_s;
        zero_q  <= (res_s == '0);
        neg_q   <= res_s[WORD_SIZE-1];
      end
    end else if (state_q == EXEC) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last_s) begin
        out_q   <= acc_d[WORD_SIZE-1:0];
        carry_q <= 1'b0;
        ovf_q   <= (acc_d[2*WORD_SIZE-1:WORD_SIZE] != '0);
        zero_q  <= (acc_d[WORD_SIZE-1:0] == '0);
        neg_q   <= acc_d[WORD_SIZE-1];
      end
    end
  end
endmodule
